// File: rtl/bpu_pkg.sv
// Shared branch-prediction types and constants for the fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bpu_pkg;

    // Fetch addresses are 32-bit byte addresses carried as 30-bit word addresses.
    localparam int PC_W = 30;

    // Boot vector as a word address (byte address 0x1C00_0000).
    localparam logic [PC_W-1:0] RESET_PC_DEF = 30'h0700_0000;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_DIRECT = 2'b01,
        BR_CALL   = 2'b10,
        BR_RET    = 2'b11
    } br_type_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with {ptr,cnt} checkpoint/restore.
// Latency: top/cnt/ckpt are registered state, visible the cycle after push/pop/restore.
// Backpressure: none; push overwrites the oldest entry when full, pop when empty is ignored.
module ras_stack
    import bpu_pkg::*;
#(
    parameter int  RAS_DEPTH = 8,
    localparam int RAS_PW    = $clog2(RAS_DEPTH),
    localparam int RAS_CW    = $clog2(RAS_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [PC_W-1:0]          push_data,
    input  logic                     pop,
    input  logic                     restore,
    input  logic [RAS_PW+RAS_CW-1:0] restore_ckpt,
    output logic [PC_W-1:0]          top,
    output logic [RAS_CW-1:0]        cnt,
    output logic [RAS_PW+RAS_CW-1:0] ckpt
);

    logic [PC_W-1:0]   stack_q [RAS_DEPTH];
    logic [RAS_PW-1:0] ptr_q;
    logic [RAS_CW-1:0] cnt_q;

    // ptr points one past the most recent entry, so the top lives at ptr-1.
    assign top  = stack_q[ptr_q - RAS_PW'(1)];
    assign cnt  = cnt_q;
    assign ckpt = {ptr_q, cnt_q};

    // Pointer and occupancy; restore wins over push/pop, count saturates at depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (restore) begin
            {ptr_q, cnt_q} <= restore_ckpt;
        end else if (push) begin
            ptr_q <= ptr_q + RAS_PW'(1);
            if (cnt_q != RAS_CW'(RAS_DEPTH)) begin
                cnt_q <= cnt_q + RAS_CW'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_q <= ptr_q - RAS_PW'(1);
            cnt_q <= cnt_q - RAS_CW'(1);
        end
    end

    // Entry storage carries no reset; stale slots are never read while cnt says empty.
    always_ff @(posedge clk) begin
        if (push && !restore && !rst) begin
            stack_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/npc_gen.sv
// Next-PC generator: holds fetch PC, picks seq/BTB/RAS/redirect next PC; build option NPC_RAS_EN adds the RAS.
// Latency: zero-cycle prediction from same-cycle BTB data; next pc registered one cycle after fire/redirect.
// Backpressure: fetch_ready low stalls pc and RAS; redirect overrides stall and valid.
module npc_gen
    import bpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int              RAS_DEPTH = 8,
    localparam int             RAS_PW    = $clog2(RAS_DEPTH),
    localparam int             RAS_CW    = $clog2(RAS_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [PC_W-1:0]          pc,
    output logic                     pc_valid,
    input  logic                     fetch_ready,
    input  logic [1:0]               btb_br_type,
    input  logic [PC_W-1:0]          btb_br_target,
    output logic [1:0]               pred_type,
    output logic [PC_W-1:0]          pred_npc,
    output logic [RAS_PW+RAS_CW-1:0] pred_ras_ckpt,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic [RAS_PW+RAS_CW-1:0] redirect_ras_ckpt
);

    logic            fire;
    logic [PC_W-1:0] seq_pc;
    br_type_t        btb_type;
    br_type_t        type_c;
    logic [PC_W-1:0] npc_c;

    assign fire     = pc_valid & fetch_ready & ~redirect;
    assign seq_pc   = pc + PC_W'(1);
    assign btb_type = br_type_t'(btb_br_type);

`ifdef NPC_RAS_EN
    logic [PC_W-1:0]   ras_top;
    logic [RAS_CW-1:0] ras_cnt;
    logic              ras_push;
    logic              ras_pop;

    assign ras_push = fire & (btb_type == BR_CALL);
    assign ras_pop  = fire & (btb_type == BR_RET) & (ras_cnt != '0);

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk          (clk),
        .rst          (rst),
        .push         (ras_push),
        .push_data    (seq_pc),
        .pop          (ras_pop),
        .restore      (redirect),
        .restore_ckpt (redirect_ras_ckpt),
        .top          (ras_top),
        .cnt          (ras_cnt),
        .ckpt         (pred_ras_ckpt)
    );
`else
    logic unused_ckpt;

    assign unused_ckpt   = ^redirect_ras_ckpt;
    assign pred_ras_ckpt = '0;
`endif

    // Next-PC select; an empty-RAS return degrades to a direct prediction on the BTB target.
    always_comb begin
        type_c = btb_type;
        npc_c  = seq_pc;
        unique case (btb_type)
            BR_NONE:   npc_c = seq_pc;
            BR_DIRECT: npc_c = btb_br_target;
            BR_CALL:   npc_c = btb_br_target;
            BR_RET: begin
`ifdef NPC_RAS_EN
                if (ras_cnt != '0) begin
                    npc_c = ras_top;
                end else begin
                    npc_c  = btb_br_target;
                    type_c = BR_DIRECT;
                end
`else
                npc_c = btb_br_target;
`endif
            end
            default:   npc_c = seq_pc;
        endcase
    end

    assign pred_type = type_c;
    assign pred_npc  = npc_c;

    // PC register: reset, then redirect, then accepted fetch; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (fire) begin
                pc <= npc_c;
            end
        end
    end

endmodule

// File: tb/tb_npc_gen.sv
// Testbench for npc_gen: scenario tasks with a queue of expected next-PC values.
// Latency: expects next pc one edge after each fire/redirect.
// Backpressure: exercises fetch_ready stalls and redirect during stall.
module tb_npc_gen;
    import bpu_pkg::*;

    localparam logic [29:0] RST_PC = 30'h0700_0000;
    localparam int          CKW    = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [29:0]     pc;
    logic            pc_valid;
    logic            fetch_ready;
    logic [1:0]      btb_br_type;
    logic [29:0]     btb_br_target;
    logic [1:0]      pred_type;
    logic [29:0]     pred_npc;
    logic [CKW-1:0]  pred_ras_ckpt;
    logic            redirect;
    logic [29:0]     redirect_pc;
    logic [CKW-1:0]  redirect_ras_ckpt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [29:0] exp_q[$];
    logic [29:0] exp_pc;
    logic [29:0] model_pc;

    npc_gen dut (
        .clk               (clk),
        .rst               (rst),
        .pc                (pc),
        .pc_valid          (pc_valid),
        .fetch_ready       (fetch_ready),
        .btb_br_type       (btb_br_type),
        .btb_br_target     (btb_br_target),
        .pred_type         (pred_type),
        .pred_npc          (pred_npc),
        .pred_ras_ckpt     (pred_ras_ckpt),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .redirect_ras_ckpt (redirect_ras_ckpt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [29:0] tgt, input logic rdy,
                         input logic rd, input logic [29:0] rpc, input logic [CKW-1:0] rck);
        btb_br_type       = t;
        btb_br_target     = tgt;
        fetch_ready       = rdy;
        redirect          = rd;
        redirect_pc       = rpc;
        redirect_ras_ckpt = rck;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b00, 30'h0, 1'b0, 1'b0, 30'h0, '0);
        repeat (3) tick();
        n_checks++;
        if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        n_checks++;
        if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
        n_checks++;
        if (pred_type !== 2'b00) begin n_fail++; $display("FAIL reset_ptype: got %b want 00", pred_type); end
        n_checks++;
        if (pred_npc !== RST_PC + 30'd1) begin n_fail++; $display("FAIL reset_npc: got %h want %h", pred_npc, RST_PC + 30'd1); end
        n_checks++;
        if (pred_ras_ckpt !== '0) begin n_fail++; $display("FAIL reset_ckpt: got %h want 0", pred_ras_ckpt); end
        rst = 1'b0;
        drive(2'b00, 30'h0, 1'b1, 1'b0, 30'h0, '0);
        exp_q.push_back(RST_PC);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL release_pc: got %h want %h", pc, exp_pc); end
        n_checks++;
        if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid: got %b want 1", pc_valid); end
        for (int i = 1; i <= 2; i++) begin
            exp_q.push_back(RST_PC + 30'(i));
            tick();
            exp_pc = exp_q.pop_front();
            n_checks++;
            if (pc !== exp_pc) begin n_fail++; $display("FAIL seq_step%0d: got %h want %h", i, pc, exp_pc); end
        end
    endtask

    task automatic test_call_ret();
`ifdef NPC_RAS_EN
        drive(2'b00, 30'h0, 1'b1, 1'b1, 30'h100, '0);
        exp_q.push_back(30'h100);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL cr_redir: got %h want %h", pc, exp_pc); end
        drive(2'b10, 30'h200, 1'b1, 1'b0, 30'h0, '0);
        n_checks++;
        if (pred_npc !== 30'h200 || pred_type !== 2'b10) begin n_fail++; $display("FAIL call_pred: got %h/%b want 200/10", pred_npc, pred_type); end
        exp_q.push_back(30'h200);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL call_pc: got %h want %h", pc, exp_pc); end
        n_checks++;
        if (pred_ras_ckpt !== {3'd1, 4'd1}) begin n_fail++; $display("FAIL call_ckpt: got %h want %h", pred_ras_ckpt, {3'd1, 4'd1}); end
        drive(2'b01, 30'h210, 1'b1, 1'b0, 30'h0, '0);
        exp_q.push_back(30'h210);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL direct_pc: got %h want %h", pc, exp_pc); end
        drive(2'b11, 30'h999, 1'b1, 1'b0, 30'h0, '0);
        n_checks++;
        if (pred_npc !== 30'h101 || pred_type !== 2'b11) begin n_fail++; $display("FAIL ret_pred: got %h/%b want 101/11", pred_npc, pred_type); end
        exp_q.push_back(30'h101);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL ret_pc: got %h want %h", pc, exp_pc); end
        n_checks++;
        if (pred_ras_ckpt !== '0) begin n_fail++; $display("FAIL ret_ckpt: got %h want 0", pred_ras_ckpt); end
`else
        drive(2'b00, 30'h0, 1'b1, 1'b1, 30'h210, 7'h55);
        exp_q.push_back(30'h210);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL nr_redir: got %h want %h", pc, exp_pc); end
        drive(2'b11, 30'h999, 1'b1, 1'b0, 30'h0, '0);
        n_checks++;
        if (pred_npc !== 30'h999 || pred_type !== 2'b11) begin n_fail++; $display("FAIL nr_ret_pred: got %h/%b want 999/11", pred_npc, pred_type); end
        n_checks++;
        if (pred_ras_ckpt !== '0) begin n_fail++; $display("FAIL nr_ckpt: got %h want 0", pred_ras_ckpt); end
        exp_q.push_back(30'h999);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL nr_ret_pc: got %h want %h", pc, exp_pc); end
`endif
    endtask

    task automatic test_overflow();
`ifdef NPC_RAS_EN
        drive(2'b00, 30'h0, 1'b1, 1'b1, 30'h10, '0);
        exp_q.push_back(30'h10);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL ovf_redir: got %h want %h", pc, exp_pc); end
        for (int i = 0; i < 9; i++) begin
            drive(2'b10, 30'h11 + 30'(i), 1'b1, 1'b0, 30'h0, '0);
            exp_q.push_back(30'h11 + 30'(i));
            tick();
            exp_pc = exp_q.pop_front();
            n_checks++;
            if (pc !== exp_pc) begin n_fail++; $display("FAIL ovf_call%0d: got %h want %h", i, pc, exp_pc); end
        end
        n_checks++;
        if (pred_ras_ckpt !== {3'd1, 4'd8}) begin n_fail++; $display("FAIL ovf_full_ckpt: got %h want %h", pred_ras_ckpt, {3'd1, 4'd8}); end
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 30'h555, 1'b1, 1'b0, 30'h0, '0);
            exp_q.push_back(30'h19 - 30'(i));
            tick();
            exp_pc = exp_q.pop_front();
            n_checks++;
            if (pc !== exp_pc) begin n_fail++; $display("FAIL ovf_ret%0d: got %h want %h", i, pc, exp_pc); end
        end
        drive(2'b11, 30'h555, 1'b1, 1'b0, 30'h0, '0);
        n_checks++;
        if (pred_type !== 2'b01 || pred_npc !== 30'h555) begin n_fail++; $display("FAIL ovf_empty_pred: got %b/%h want 01/555", pred_type, pred_npc); end
        exp_q.push_back(30'h555);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL ovf_empty_pc: got %h want %h", pc, exp_pc); end
`endif
    endtask

    task automatic test_redirect_stall();
        logic [CKW-1:0] exp_ck;
        drive(2'b00, 30'h0, 1'b1, 1'b1, 30'h80, {3'd1, 4'd1});
        exp_q.push_back(30'h80);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL rs_redir: got %h want %h", pc, exp_pc); end
        drive(2'b10, 30'h300, 1'b0, 1'b0, 30'h0, '0);
        repeat (2) begin
            exp_q.push_back(30'h80);
            tick();
            exp_pc = exp_q.pop_front();
            n_checks++;
            if (pc !== exp_pc || pred_npc !== 30'h300) begin n_fail++; $display("FAIL stall_hold: got %h/%h want %h/300", pc, pred_npc, exp_pc); end
        end
`ifdef NPC_RAS_EN
        exp_ck = {3'd1, 4'd1};
`else
        exp_ck = '0;
`endif
        n_checks++;
        if (pred_ras_ckpt !== exp_ck) begin n_fail++; $display("FAIL stall_ckpt: got %h want %h", pred_ras_ckpt, exp_ck); end
        drive(2'b10, 30'h300, 1'b0, 1'b1, 30'h40, {3'd3, 4'd2});
        exp_q.push_back(30'h40);
        tick();
        exp_pc = exp_q.pop_front();
        drive(2'b00, 30'h0, 1'b0, 1'b0, 30'h0, '0);
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL rs_pc: got %h want %h", pc, exp_pc); end
`ifdef NPC_RAS_EN
        exp_ck = {3'd3, 4'd2};
`else
        exp_ck = '0;
`endif
        n_checks++;
        if (pred_ras_ckpt !== exp_ck) begin n_fail++; $display("FAIL rs_ckpt: got %h want %h", pred_ras_ckpt, exp_ck); end
    endtask

    task automatic test_wrap();
        drive(2'b00, 30'h0, 1'b1, 1'b1, 30'h3FFF_FFFF, '0);
        exp_q.push_back(30'h3FFF_FFFF);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL wrap_redir: got %h want %h", pc, exp_pc); end
        drive(2'b00, 30'h123, 1'b1, 1'b0, 30'h0, '0);
        n_checks++;
        if (pred_npc !== 30'h0) begin n_fail++; $display("FAIL wrap_pred: got %h want 0", pred_npc); end
        exp_q.push_back(30'h0);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  t;
        logic [29:0] tgt;
        model_pc = 30'h0;
        for (int i = 0; i < 12; i++) begin
            t   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
            tgt = 30'($urandom_range(0, 30'h0FFF_FFFF));
            drive(t, tgt, 1'b1, 1'b0, 30'h0, '0);
            model_pc = (t == 2'b00) ? model_pc + 30'd1 : tgt;
            exp_q.push_back(model_pc);
            tick();
            exp_pc = exp_q.pop_front();
            n_checks++;
            if (pc !== exp_pc) begin n_fail++; $display("FAIL b2b_%0d: got %h want %h", i, pc, exp_pc); end
        end
    endtask

    task automatic test_mid_reset();
        drive(2'b01, 30'h77, 1'b1, 1'b1, 30'h33, {3'd2, 4'd2});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(2'b00, 30'h0, 1'b1, 1'b0, 30'h0, '0);
        n_checks++;
        if (pc !== RST_PC || pc_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got %h/%b want %h/0", pc, pc_valid, RST_PC); end
        n_checks++;
        if (pred_ras_ckpt !== '0) begin n_fail++; $display("FAIL midrst_ckpt: got %h want 0", pred_ras_ckpt); end
        exp_q.push_back(RST_PC);
        tick();
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (pc !== exp_pc || pc_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_release: got %h/%b want %h/1", pc, pc_valid, exp_pc); end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_overflow();
        test_redirect_stall();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/npc_gen.md
# npc_gen

Next-PC generator for the fetch front end. It holds the fetch PC and presents it to the BTB lookup. In the same cycle it consumes the BTB's `br_type`/`br_target` and selects the next PC from sequential, BTB target, return-address-stack top, or backend redirect. It also exports the prediction that travels down the pipeline, so the branch unit can check it and repair the RAS.

## Interface
Parameters:
- `RESET_PC`, default 30'h0700_0000: word address loaded on reset (byte 0x1C00_0000).
- `RAS_DEPTH`, default 8: return-address-stack entries; must be a power of two, ≥2.

Ports (`RAS_PW = $clog2(RAS_DEPTH)`, `RAS_CW = $clog2(RAS_DEPTH+1)`):
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `pc` out 30: current fetch word address; drives the BTB `pc` input.
- `pc_valid` out 1: `pc` is a live fetch request.
- `fetch_ready` in 1: IF stage accepts `pc` this cycle.
- `btb_br_type` in 2: BTB prediction type for `pc`; combinational, same cycle.
- `btb_br_target` in 30: BTB target for `pc`; same cycle.
- `pred_type` out 2: type actually used for `pc` (see Operation).
- `pred_npc` out 30: next PC predicted for `pc`.
- `pred_ras_ckpt` out RAS_PW+RAS_CW: RAS `{ptr,cnt}` before this fetch's push/pop.
- `redirect` in 1: backend mispredict/exception redirect.
- `redirect_pc` in 30: redirect target.
- `redirect_ras_ckpt` in RAS_PW+RAS_CW: checkpoint to restore on redirect.

## Operation
- Type encoding:
  - 00 `BR_NONE`: miss or not a branch.
  - 01 `BR_DIRECT`: conditional or direct jump.
  - 10 `BR_CALL`: call.
  - 11 `BR_RET`: return.
- Next-PC select (combinational, drives `pred_npc`):
  - NONE: `pc+1`, modulo 2^30; wraps to 0.
  - DIRECT: `btb_br_target`.
  - CALL: `btb_br_target`.
  - RET with RAS `cnt>0`: RAS top.
  - RET with RAS empty: `btb_br_target`, and `pred_type` reports 01.
- An accepted fetch (`fire = pc_valid & fetch_ready & ~redirect`):
  - `pc <= pred_npc`.
  - CALL pushes `pc+1`.
  - RET with `cnt>0` pops.
- RAS is circular.
  - Push: `ptr <= ptr+1` (wraps), write entry, `cnt <= min(cnt+1, RAS_DEPTH)`. A push when full overwrites the oldest entry.
  - Pop: `ptr <= ptr-1`, `cnt <= cnt-1`. A pop when empty does nothing.
- Redirect has top priority, regardless of `pc_valid` and `fetch_ready`:
  - `pc <= redirect_pc`.
  - RAS `{ptr,cnt} <= redirect_ras_ckpt`; entries are not restored.
  - This cycle's prediction is discarded: no push or pop.
- Stall (`pc_valid & ~fetch_ready & ~redirect`): `pc`, RAS and all `pred_*` outputs hold.

## Timing
- Reset values:
  - `pc = RESET_PC`, `pc_valid = 0`.
  - RAS `ptr = 0`, `cnt = 0`, entries don't-care.
  - `pred_type = 00`, `pred_npc = RESET_PC+1`, `pred_ras_ckpt = 0`.
- `pc_valid` rises on the first edge after `rst` deasserts and stays 1 thereafter.
- Zero-cycle prediction: BTB outputs for `pc` are used in the same cycle. `pc` updates on the edge where `fire` or `redirect` is high, so an accepted fetch has one-cycle latency to the next `pc`.
- Redirect in cycle N: `pc == redirect_pc` in N+1, and that PC's prediction is produced in N+1.
- `rst` mid-operation overrides a simultaneous redirect or fire. The state returns to the reset values on that edge.
- `pred_*` outputs are combinational functions of `pc`, the BTB inputs and RAS state. They are valid only while `pc_valid`.

## Configuration
- `NPC_RAS_EN`:
  - Defined: RAS is instantiated as described.
  - Undefined: no RAS storage. RET uses `btb_br_target` and `pred_type` keeps 11. `pred_ras_ckpt` is tied to 0 and `redirect_ras_ckpt` is ignored.
- Port list is identical in both builds.

## Structure
- Package `bpu_pkg`:
  - `br_type_t` enum (`BR_NONE`, `BR_DIRECT`, `BR_CALL`, `BR_RET`).
  - `RESET_PC` default constant.
  - PC width constant (30).
- Sub-module `ras_stack`:
  - Parameter `RAS_DEPTH`.
  - Ports: `push`, `push_data`, `pop`, `restore`, `restore_ckpt`, `top`, `cnt`, `ckpt`.
  - Compiled in only under `NPC_RAS_EN`.
- Next-PC mux and PC register live in `npc_gen`.

## Test plan
- Reset sequence: hold `rst` 3 cycles, then release → `pc = 30'h0700_0000`, `pc_valid` = 1 one cycle later. With BTB type 00 and `fetch_ready = 1`, `pc` steps to 0700_0001, then 0700_0002.
- Call/return, `NPC_RAS_EN`:
  - CALL at `pc = 0x100`, target 0x200 → next `pc = 0x200`, RAS `cnt = 1`.
  - RET at 0x210, BTB target 0x999 → next `pc = 0x101`, `cnt = 0`.
- RAS overflow: 9 nested CALLs at `pc = 0x10..0x18`, then 9 RETs.
  - The first 8 RETs return 0x19..0x12.
  - The 9th RET finds the RAS empty and uses the BTB target, with `pred_type = 01`.
- Redirect vs stall: `fetch_ready = 0`, CALL predicted, `redirect = 1`, `redirect_pc = 0x40`, ckpt `{ptr 3, cnt 2}` → next `pc = 0x40`, no push, RAS `{3,2}`.
- Wrap: `redirect_pc = 30'h3FFF_FFFF`, type 00 → the following `pc = 0`.
- Without `NPC_RAS_EN`: RET at 0x210, BTB target 0x999 → next `pc = 0x999`, `pred_ras_ckpt = 0`.
